// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds decoder opcodes, the fetch FSM encoding, the default reset PC and an opcode helper.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    function automatic logic [OP_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with synchronous flush.
// Flush overrides push/pop; storage resets to RST_VAL so the head reads a known value.
module fetch_fifo #(
    parameter int unsigned       DEPTH   = 2,
    parameter int unsigned       WIDTH   = 64,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_i && pop_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC stream, credit-limited imem requests, prefetch buffer, redirect flush.
// Define FETCH_ALIGN_CHECK_EN to add the sticky misalign_o flag for unaligned redirect targets.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                imem_req_o,
    output logic [ADDR_W-1:0]   imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [INSTR_W-1:0]  imem_rdata_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [OP_W-1:0]     instr_op_o,
    output logic [ADDR_W-1:0]   pc_o,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                misalign_o
`endif
);
    localparam int unsigned CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   discard_q, discard_d;
    logic               req_q, req_d;

    logic [CNT_W-1:0]   buf_count;
    logic [CNT_W-1:0]   buf_count_nxt_c;
    logic [SUM_W-1:0]   credit_used_c;
    logic               buf_full, buf_empty;
    logic               gnt_c, push_c, pop_c;
    logic [ADDR_W-1:0]  redirect_pc_c, resp_pc_c;
    logic [ENTRY_W-1:0] head;

    assign redirect_pc_c = redirect_pc_i & ~ADDR_W'(3);
    // Live requests are contiguous behind fetch_pc, so the oldest one sits outstanding words back.
    assign resp_pc_c     = fetch_pc_q - (ADDR_W'(outstanding_q) << 2);

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        outstanding_d   = outstanding_q;
        discard_d       = discard_q;
        gnt_c           = req_q & imem_gnt_i;
        push_c          = imem_rvalid_i && (state_q == ST_FETCH) && !redirect_i;
        pop_c           = instr_valid_o && instr_ready_i && !redirect_i;
        buf_count_nxt_c = buf_count;

        if (gnt_c) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
        if (gnt_c && !imem_rvalid_i) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!gnt_c && imem_rvalid_i) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        if (state_q == ST_FLUSH) begin
            if (imem_rvalid_i) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (discard_d == '0) begin
                state_d = ST_FETCH;
            end
        end

        // Everything still in flight after this edge belongs to the old stream.
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_c;
            discard_d  = outstanding_d;
            state_d    = (outstanding_d == '0) ? ST_FETCH : ST_FLUSH;
        end

        if (redirect_i) begin
            buf_count_nxt_c = '0;
        end else if (push_c && !pop_c) begin
            buf_count_nxt_c = buf_count + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            buf_count_nxt_c = buf_count - CNT_W'(1);
        end

        credit_used_c = SUM_W'(buf_count_nxt_c) + SUM_W'(outstanding_d);
        req_d         = (state_d == ST_FETCH) && (credit_used_c < SUM_W'(BUF_DEPTH));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_FETCH;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            req_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            req_q         <= req_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (BUF_DEPTH),
        .WIDTH   (ENTRY_W),
        .RST_VAL ({{INSTR_W{1'b0}}, RESET_PC})
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push_c),
        .data_i  ({imem_rdata_i, resp_pc_c}),
        .pop_i   (pop_c),
        .data_o  (head),
        .count_o (buf_count),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign imem_req_o    = req_q;
    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = !buf_empty;
    assign instr_o       = head[ENTRY_W-1 -: INSTR_W];
    assign pc_o          = head[ADDR_W-1:0];
    assign instr_op_o    = instr_opcode(instr_o);

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_o = misalign_q;
`endif

    rvalid_has_credit_a: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> (outstanding_q != '0));

    no_push_when_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
        push_c |-> (!buf_full || pop_c));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random imem latency/grant, consumer stalls and redirects
// checked against a stream-level model (expected fetch address and expected consumed PC).
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [5:0]  instr_op_o;
    logic [31:0] pc_o;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    instr_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_op_o    (instr_op_o),
        .pc_o          (pc_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pend[$];
    int unsigned cyc = 0;
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_pc    = RST_PC;
    int unsigned stale = 0;
    bit          expect_invalid = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int unsigned cons_cnt = 0;
    int unsigned hs_cnt = 0;

    int unsigned gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1, redir_pm = 0;
    bit          redir_on_both = 1'b0, both_seen = 1'b0, force_redir = 1'b0;
    logic [31:0] force_pc = 32'h0, both_pc = 32'h100;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        pend.delete();
        stale          = 0;
        exp_fetch      = RST_PC;
        exp_pc         = RST_PC;
        expect_invalid = 1'b0;
        imem_gnt_i     = 1'b0;
        imem_rvalid_i  = 1'b0;
        redirect_i     = 1'b0;
        instr_ready_i  = 1'b0;
    endtask

    // One clock: check outputs, drive inputs for the next edge, advance the model through that edge.
    task automatic step();
        logic        hs, rv, redir, cons;
        logic [31:0] rpc, w;
        int unsigned lat;
        @(negedge clk_i);
        cyc++;
        if (expect_invalid) check_eq("valid_after_redirect", 32'(instr_valid_o), 32'd0);
        if (stale > 0) check_eq("no_req_in_flush", 32'(imem_req_o), 32'd0);
        if (instr_valid_o) check_eq("head_word", instr_o, mem_word(pc_o));

        imem_gnt_i    = ($urandom_range(99) < gnt_pct);
        instr_ready_i = ($urandom_range(99) < rdy_pct);
        rv            = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word(pend[0].addr) : $urandom;
        hs            = imem_req_o && imem_gnt_i;

        redir = 1'b0;
        rpc   = $urandom;
        if (force_redir) begin
            redir       = 1'b1;
            rpc         = force_pc;
            force_redir = 1'b0;
        end else if (redir_on_both && hs && rv) begin
            redir     = 1'b1;
            rpc       = both_pc;
            both_seen = 1'b1;
        end else if ($urandom_range(999) < redir_pm) begin
            redir = 1'b1;
            case ($urandom_range(3))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF8;
                2:       rpc = 32'h0000_0040;
                default: rpc = $urandom & 32'h0000_0FFC;
            endcase
        end
        redirect_i    = redir;
        redirect_pc_i = rpc;

        if (hs) begin
            check_eq("fetch_addr", imem_addr_o, exp_fetch);
            lat = $urandom_range(lat_max, lat_min);
            pend.push_back('{addr: imem_addr_o, due: cyc + lat});
            exp_fetch = exp_fetch + 32'd4;
            hs_cnt++;
        end
        if (rv) begin
            void'(pend.pop_front());
            if (stale > 0) stale--;
        end
        check_eq("credit", 32'(pend.size() <= DEPTH), 32'd1);

        cons = instr_valid_o && instr_ready_i && !redir;
        if (cons) begin
            w = mem_word(exp_pc);
            check_eq("pc", pc_o, exp_pc);
            check_eq("op", 32'(instr_op_o), 32'(w[31:26]));
            exp_pc = exp_pc + 32'd4;
            cons_cnt++;
        end

        expect_invalid = redir;
        if (redir) begin
            stale     = pend.size();
            exp_fetch = rpc & 32'hFFFF_FFFC;
            exp_pc    = rpc & 32'hFFFF_FFFC;
        end
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        clear_model();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic set_knobs(input int unsigned g, input int unsigned r, input int unsigned lmin,
                             input int unsigned lmax, input int unsigned rpm);
        gnt_pct  = g;
        rdy_pct  = r;
        lat_min  = lmin;
        lat_max  = lmax;
        redir_pm = rpm;
    endtask

    initial begin
        int unsigned c0;
        int unsigned h0;

        // Reset values while held in reset
        repeat (3) @(negedge clk_i);
        check_eq("rst_req", 32'(imem_req_o), 32'd0);
        check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
        check_eq("rst_instr", instr_o, 32'd0);
        check_eq("rst_pc", pc_o, RST_PC);
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("rst_misalign", 32'(misalign_o), 32'd0);
`endif
        rst_i = 1'b0;

        // 1: single-cycle memory, always ready
        set_knobs(100, 100, 1, 1, 0);
        c0 = cons_cnt;
        run(30);
        check_eq("t1_progress", 32'(cons_cnt - c0 >= 10), 32'd1);

        // 2: stalled consumer gets exactly BUF_DEPTH requests, then drains in order
        apply_reset();
        set_knobs(100, 0, 1, 1, 0);
        h0 = hs_cnt;
        run(10);
        check_eq("t2_req_count", hs_cnt - h0, DEPTH);
        check_eq("t2_req_low", 32'(imem_req_o), 32'd0);
        rdy_pct = 100;
        c0 = cons_cnt;
        run(20);
        check_eq("t2_drain", 32'(cons_cnt - c0 >= 8), 32'd1);

        // 3: redirect with two responses in flight on a 3-cycle memory
        apply_reset();
        set_knobs(100, 0, 3, 3, 0);
        for (int i = 0; i < 20 && pend.size() != 2; i++) step();
        check_eq("t3_two_inflight", 32'(pend.size()), 32'd2);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0040;
        step();
        check_eq("t3_discard", stale, 32'd2);
        rdy_pct = 100;
        c0 = cons_cnt;
        run(30);
        check_eq("t3_progress", 32'(cons_cnt - c0 >= 4), 32'd1);

        // 4: redirect in the same cycle as a grant and a response
        apply_reset();
        set_knobs(100, 50, 1, 1, 0);
        redir_on_both = 1'b1;
        both_seen     = 1'b0;
        for (int i = 0; i < 60 && !both_seen; i++) step();
        redir_on_both = 1'b0;
        check_eq("t4_trigger", 32'(both_seen), 32'd1);
        c0 = cons_cnt;
        run(30);
        check_eq("t4_progress", 32'(cons_cnt - c0 >= 4), 32'd1);

        // 5: address wrap, then an unaligned redirect target
        set_knobs(100, 100, 1, 1, 0);
        force_redir = 1'b1;
        force_pc    = 32'hFFFF_FFFC;
        c0 = cons_cnt;
        run(15);
        check_eq("t5_wrap_progress", 32'(cons_cnt - c0 >= 3), 32'd1);
        force_redir = 1'b1;
        force_pc    = 32'h0000_0042;
        c0 = cons_cnt;
        run(15);
        check_eq("t5_align_progress", 32'(cons_cnt - c0 >= 3), 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("t5_misalign", 32'(misalign_o), 32'd1);
`endif

        // 6: asynchronous reset with a full buffer
        set_knobs(100, 0, 1, 1, 0);
        run(10);
        check_eq("t6_full_valid", 32'(instr_valid_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check_eq("t6_async_req", 32'(imem_req_o), 32'd0);
        check_eq("t6_async_valid", 32'(instr_valid_o), 32'd0);
        check_eq("t6_async_pc", pc_o, RST_PC);
        clear_model();
        @(negedge clk_i);
        rst_i = 1'b0;
        rdy_pct = 100;
        c0 = cons_cnt;
        run(20);
        check_eq("t6_refetch", 32'(cons_cnt - c0 >= 6), 32'd1);

        // Random traffic: grants, latency, stalls and redirects all varied
        set_knobs(70, 60, 1, 4, 30);
        c0 = cons_cnt;
        run(3000);
        check_eq("rand_progress", 32'(cons_cnt - c0 >= 300), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule
